regfile_mp_scoreboard: RTL and testbench

//  Parametrised multi-port integer register file for the s2_decode stage.
//  - Adds configurable read and write ports and write-to-read bypass.
//  - Adds a pending-write scoreboard, so decode can detect RAW hazards on in-flight producers.
//  - Adds a post-reset sequential clear sweep, so the storage can map onto SRAM-style arrays without a global reset.

---
 rtl/regfile_mp_scoreboard.sv | 145 ++++++++++++++
 tb/tb_regfile_mp_scoreboard.sv | 376 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_mp_scoreboard.sv
// ---------------------------------------------------------------------------
// regfile_mp_scoreboard
//   Multi-port integer register file for the decode stage. It has a
//   write-to-read bypass and a pending-write scoreboard for RAW hazard
//   detection. After reset, a sequential clear sweep zeroes the storage,
//   so the array itself needs no global reset.
//
// Ports
//   clk          clock
//   rst_n        synchronous active-low reset
//   o_ready      1 once the clear sweep is done and traffic is accepted
//   i_rd_en      per-port read enable                [NRD]
//   i_rd_addr    read addresses                      [NRD][AW]
//   o_rd_dat     read data, combinational            [NRD][XLEN]
//   o_rd_busy    read register has an unbypassed pending producer [NRD]
//   i_wr_en      per-port writeback enable           [NWR]
//   i_wr_addr    write addresses                     [NWR][AW]
//   i_wr_dat     write data                          [NWR][XLEN]
//   i_iss_en     mark i_iss_addr as pending
//   i_iss_addr   destination register being issued   [AW]
//   i_flush      clear every pending bit
// ---------------------------------------------------------------------------
module regfile_mp_scoreboard #(
    parameter int unsigned XLEN     = 32,
    parameter int unsigned NREGS    = 32,
    parameter int unsigned NRD      = 2,
    parameter int unsigned NWR      = 2,
    parameter bit          ZERO_REG = 1'b1,
    localparam int unsigned AW      = (NREGS > 1) ? $clog2(NREGS) : 1
) (
    input  logic                           clk,
    input  logic                           rst_n,
    output logic                           o_ready,
    input  logic [NRD-1:0]                 i_rd_en,
    input  logic [NRD-1:0][AW-1:0]         i_rd_addr,
    output logic [NRD-1:0][XLEN-1:0]       o_rd_dat,
    output logic [NRD-1:0]                 o_rd_busy,
    input  logic [NWR-1:0]                 i_wr_en,
    input  logic [NWR-1:0][AW-1:0]         i_wr_addr,
    input  logic [NWR-1:0][XLEN-1:0]       i_wr_dat,
    input  logic                           i_iss_en,
    input  logic [AW-1:0]                  i_iss_addr,
    input  logic                           i_flush
);

    localparam logic [0:0]    ST_INIT  = 1'b0;
    localparam logic [0:0]    ST_RUN   = 1'b1;
    localparam logic [AW-1:0] LAST_IDX = AW'(NREGS - 1);

    logic [0:0]       r_state;
    logic [AW-1:0]    r_ptr;
    logic [NREGS-1:0] r_pending;
    logic [XLEN-1:0]  r_regs [NREGS];

    logic             w_run;
    logic [NWR-1:0]   w_wr_ok;
    logic             w_iss_ok;
    logic [NREGS-1:0] w_pending_d;
    logic [NRD-1:0]   w_bypass_hit;

    // Address maps onto a real, writable register (excludes x0 when hardwired).
    function automatic logic f_addr_ok(input logic [AW-1:0] addr);
        logic in_range;
        in_range  = ({{(32-AW){1'b0}}, addr} < NREGS);
        f_addr_ok = in_range && !(ZERO_REG && (addr == '0));
    endfunction

    assign w_run   = (r_state == ST_RUN);
    assign o_ready = w_run;

    always_comb begin
        for (int j = 0; j < NWR; j++) begin
            w_wr_ok[j] = w_run && i_wr_en[j] && f_addr_ok(i_wr_addr[j]);
        end
        w_iss_ok = w_run && i_iss_en && f_addr_ok(i_iss_addr);
    end

    // Scoreboard next state: write clears, then issue sets (new producer wins),
    // then flush overrides everything.
    always_comb begin
        w_pending_d = r_pending;
        for (int j = 0; j < NWR; j++) begin
            if (w_wr_ok[j]) begin
                w_pending_d[i_wr_addr[j]] = 1'b0;
            end
        end
        if (w_iss_ok) begin
            w_pending_d[i_iss_addr] = 1'b1;
        end
        if (w_run && i_flush) begin
            w_pending_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state   <= ST_INIT;
            r_ptr     <= '0;
            r_pending <= '0;
        end else begin
            if (r_state == ST_INIT) begin
                r_ptr <= r_ptr + 1'b1;
                if (r_ptr == LAST_IDX) begin
                    r_state <= ST_RUN;
                end
            end
            r_pending <= w_pending_d;
        end
    end

    // Storage has no reset; the INIT sweep zeroes it one entry per cycle.
    // Ascending port order makes the highest-index port win on collisions.
    always_ff @(posedge clk) begin
        if (r_state == ST_INIT) begin
            r_regs[r_ptr] <= '0;
        end else begin
            for (int j = 0; j < NWR; j++) begin
                if (w_wr_ok[j]) begin
                    r_regs[i_wr_addr[j]] <= i_wr_dat[j];
                end
            end
        end
    end

    // Read path with bypass; the last matching port in ascending order has
    // the highest priority, consistent with the write path.
    always_comb begin
        for (int i = 0; i < NRD; i++) begin
            w_bypass_hit[i] = 1'b0;
            o_rd_dat[i]     = '0;
            o_rd_busy[i]    = 1'b0;
            if (w_run && i_rd_en[i] && f_addr_ok(i_rd_addr[i])) begin
                o_rd_dat[i] = r_regs[i_rd_addr[i]];
                for (int j = 0; j < NWR; j++) begin
                    if (w_wr_ok[j] && (i_wr_addr[j] == i_rd_addr[i])) begin
                        w_bypass_hit[i] = 1'b1;
                        o_rd_dat[i]     = i_wr_dat[j];
                    end
                end
                o_rd_busy[i] = r_pending[i_rd_addr[i]] & ~w_bypass_hit[i];
            end
        end
    end

endmodule

// File: tb/tb_regfile_mp_scoreboard.sv
// ---------------------------------------------------------------------------
// tb_regfile_mp_scoreboard
//   Directed self-checking bench for regfile_mp_scoreboard with default
//   parameters (XLEN=32, NREGS=32, NRD=2, NWR=2, ZERO_REG=1).
// ---------------------------------------------------------------------------
module tb_regfile_mp_scoreboard;

    localparam int unsigned XLEN  = 32;
    localparam int unsigned NREGS = 32;
    localparam int unsigned NRD   = 2;
    localparam int unsigned NWR   = 2;
    localparam int unsigned AW    = 5;

    logic                     clk;
    logic                     rst_n;
    logic                     ready;
    logic [NRD-1:0]           rd_en;
    logic [NRD-1:0][AW-1:0]   rd_addr;
    logic [NRD-1:0][XLEN-1:0] rd_dat;
    logic [NRD-1:0]           rd_busy;
    logic [NWR-1:0]           wr_en;
    logic [NWR-1:0][AW-1:0]   wr_addr;
    logic [NWR-1:0][XLEN-1:0] wr_dat;
    logic                     iss_en;
    logic [AW-1:0]            iss_addr;
    logic                     flush;

    int checks;
    int failures;

    regfile_mp_scoreboard #(
        .XLEN     (XLEN),
        .NREGS    (NREGS),
        .NRD      (NRD),
        .NWR      (NWR),
        .ZERO_REG (1'b1)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .o_ready    (ready),
        .i_rd_en    (rd_en),
        .i_rd_addr  (rd_addr),
        .o_rd_dat   (rd_dat),
        .o_rd_busy  (rd_busy),
        .i_wr_en    (wr_en),
        .i_wr_addr  (wr_addr),
        .i_wr_dat   (wr_dat),
        .i_iss_en   (iss_en),
        .i_iss_addr (iss_addr),
        .i_flush    (flush)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one clock; inputs are then driven 1 time unit after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        rd_en    = '0;
        rd_addr  = '0;
        wr_en    = '0;
        wr_addr  = '0;
        wr_dat   = '0;
        iss_en   = 1'b0;
        iss_addr = '0;
        flush    = 1'b0;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst_n = 1'b0;
        step();
        step();
        step();
        rst_n = 1'b1;
        // Writes, issues and reads during the sweep must be inert.
        for (int k = 0; k < NREGS; k++) begin
            wr_en      = 2'b11;
            wr_addr[0] = 5'd5;
            wr_dat[0]  = 32'hCAFE_0000 + k;
            wr_addr[1] = AW'(k);
            wr_dat[1]  = 32'hBEEF_0000 + k;
            iss_en     = 1'b1;
            iss_addr   = 5'd6;
            rd_en      = 2'b11;
            rd_addr[0] = 5'd5;
            rd_addr[1] = AW'(k);
            #1;
            checks++;
            if (ready !== 1'b0) begin
                failures++;
                $display("FAIL reset_ready_low cycle=%0d got=%b exp=0", k, ready);
            end
            if (k == 16) begin
                checks++;
                if (rd_dat[0] !== '0 || rd_busy !== '0) begin
                    failures++;
                    $display("FAIL init_read_zero got dat=%h busy=%b exp dat=0 busy=0",
                             rd_dat[0], rd_busy);
                end
            end
            step();
        end
        idle_inputs();
        #1;
        checks++;
        if (ready !== 1'b1) begin
            failures++;
            $display("FAIL reset_ready_high got=%b exp=1", ready);
        end
        for (int a = 0; a < NREGS; a += 2) begin
            rd_en      = 2'b11;
            rd_addr[0] = AW'(a);
            rd_addr[1] = AW'(a + 1);
            #1;
            checks++;
            if (rd_dat !== '0 || rd_busy !== '0) begin
                failures++;
                $display("FAIL reset_regs_zero addr=%0d got dat=%h busy=%b exp 0", a, rd_dat,
                         rd_busy);
            end
        end
        idle_inputs();
    endtask

    task automatic test_write_priority();
        wr_en      = 2'b11;
        wr_addr[0] = 5'd5;
        wr_dat[0]  = 32'hAAAA_0000;
        wr_addr[1] = 5'd5;
        wr_dat[1]  = 32'h5555_FFFF;
        rd_en      = 2'b01;
        rd_addr[0] = 5'd5;
        rd_addr[1] = 5'd5;
        #1;
        checks++;
        if (rd_dat[0] !== 32'h5555_FFFF) begin
            failures++;
            $display("FAIL prio_bypass got=%h exp=5555ffff", rd_dat[0]);
        end
        checks++;
        if (rd_dat[1] !== 32'h0) begin
            failures++;
            $display("FAIL rd_disabled_zero got=%h exp=0", rd_dat[1]);
        end
        step();
        wr_en = '0;
        rd_en = 2'b11;
        #1;
        checks++;
        if (rd_dat[0] !== 32'h5555_FFFF || rd_dat[1] !== 32'h5555_FFFF) begin
            failures++;
            $display("FAIL prio_storage got=%h/%h exp=5555ffff", rd_dat[0], rd_dat[1]);
        end
        // Single lower-priority write, seen via port1 bypass then storage.
        wr_en      = 2'b01;
        wr_addr[0] = 5'd12;
        wr_dat[0]  = 32'h0123_4567;
        rd_addr[1] = 5'd12;
        #1;
        checks++;
        if (rd_dat[1] !== 32'h0123_4567 || rd_dat[0] !== 32'h5555_FFFF) begin
            failures++;
            $display("FAIL port0_bypass got=%h/%h exp=5555ffff/01234567", rd_dat[0], rd_dat[1]);
        end
        step();
        idle_inputs();
    endtask

    task automatic test_zero_reg();
        wr_en      = 2'b01;
        wr_addr[0] = 5'd0;
        wr_dat[0]  = 32'hDEAD_BEEF;
        rd_en      = 2'b01;
        rd_addr[0] = 5'd0;
        #1;
        checks++;
        if (rd_dat[0] !== 32'h0) begin
            failures++;
            $display("FAIL x0_same_cycle got=%h exp=0", rd_dat[0]);
        end
        step();
        wr_en    = '0;
        iss_en   = 1'b1;
        iss_addr = 5'd0;
        #1;
        checks++;
        if (rd_dat[0] !== 32'h0) begin
            failures++;
            $display("FAIL x0_next_cycle got=%h exp=0", rd_dat[0]);
        end
        step();
        iss_en = 1'b0;
        #1;
        checks++;
        if (rd_busy[0] !== 1'b0) begin
            failures++;
            $display("FAIL x0_issue_busy got=%b exp=0", rd_busy[0]);
        end
        idle_inputs();
    endtask

    task automatic test_scoreboard();
        iss_en     = 1'b1;
        iss_addr   = 5'd7;
        rd_en      = 2'b11;
        rd_addr[0] = 5'd7;
        rd_addr[1] = 5'd7;
        #1;
        checks++;
        if (rd_busy !== 2'b00) begin
            failures++;
            $display("FAIL issue_same_cycle_busy got=%b exp=00", rd_busy);
        end
        step();
        iss_en = 1'b0;
        #1;
        checks++;
        if (rd_busy !== 2'b11) begin
            failures++;
            $display("FAIL issue_busy got=%b exp=11", rd_busy);
        end
        rd_en = 2'b10;
        #1;
        checks++;
        if (rd_busy !== 2'b10) begin
            failures++;
            $display("FAIL busy_rd_en_gate got=%b exp=10", rd_busy);
        end
        rd_en      = 2'b11;
        wr_en      = 2'b10;
        wr_addr[1] = 5'd7;
        wr_dat[1]  = 32'h7777_0007;
        #1;
        checks++;
        if (rd_busy !== 2'b00 || rd_dat[0] !== 32'h7777_0007) begin
            failures++;
            $display("FAIL writeback_bypass got busy=%b dat=%h exp busy=00 dat=77770007",
                     rd_busy, rd_dat[0]);
        end
        step();
        wr_en = '0;
        #1;
        checks++;
        if (rd_busy !== 2'b00 || rd_dat[1] !== 32'h7777_0007) begin
            failures++;
            $display("FAIL pending_cleared got busy=%b dat=%h exp busy=00 dat=77770007",
                     rd_busy, rd_dat[1]);
        end
        idle_inputs();
    endtask

    task automatic test_issue_vs_write_flush();
        iss_en     = 1'b1;
        iss_addr   = 5'd9;
        wr_en      = 2'b01;
        wr_addr[0] = 5'd9;
        wr_dat[0]  = 32'h0000_0099;
        step();
        idle_inputs();
        rd_en      = 2'b01;
        rd_addr[0] = 5'd9;
        #1;
        checks++;
        if (rd_busy[0] !== 1'b1 || rd_dat[0] !== 32'h0000_0099) begin
            failures++;
            $display("FAIL issue_beats_write got busy=%b dat=%h exp busy=1 dat=00000099",
                     rd_busy[0], rd_dat[0]);
        end
        iss_en   = 1'b1;
        iss_addr = 5'd9;
        flush    = 1'b1;
        step();
        iss_en = 1'b0;
        flush  = 1'b0;
        #1;
        checks++;
        if (rd_busy[0] !== 1'b0) begin
            failures++;
            $display("FAIL flush_beats_issue got=%b exp=0", rd_busy[0]);
        end
        // Flush clears several pending bits at once.
        iss_en   = 1'b1;
        iss_addr = 5'd10;
        step();
        iss_addr = 5'd11;
        step();
        iss_en     = 1'b0;
        rd_en      = 2'b11;
        rd_addr[0] = 5'd10;
        rd_addr[1] = 5'd11;
        #1;
        checks++;
        if (rd_busy !== 2'b11) begin
            failures++;
            $display("FAIL multi_pending got=%b exp=11", rd_busy);
        end
        flush = 1'b1;
        step();
        flush = 1'b0;
        #1;
        checks++;
        if (rd_busy !== 2'b00) begin
            failures++;
            $display("FAIL flush_all got=%b exp=00", rd_busy);
        end
        idle_inputs();
    endtask

    task automatic test_mid_reset();
        int cnt;
        wr_en      = 2'b01;
        wr_addr[0] = 5'd3;
        wr_dat[0]  = 32'h0000_1234;
        iss_en     = 1'b1;
        iss_addr   = 5'd4;
        step();
        idle_inputs();
        rd_en      = 2'b11;
        rd_addr[0] = 5'd3;
        rd_addr[1] = 5'd4;
        #1;
        checks++;
        if (rd_dat[0] !== 32'h0000_1234 || rd_busy[1] !== 1'b1) begin
            failures++;
            $display("FAIL pre_reset got dat=%h busy=%b exp dat=00001234 busy=1",
                     rd_dat[0], rd_busy[1]);
        end
        rst_n = 1'b0;
        step();
        checks++;
        if (ready !== 1'b0) begin
            failures++;
            $display("FAIL midreset_ready_drop got=%b exp=0", ready);
        end
        rst_n = 1'b1;
        cnt   = 0;
        while (ready !== 1'b1 && cnt < 40) begin
            step();
            cnt++;
        end
        checks++;
        if (cnt != NREGS) begin
            failures++;
            $display("FAIL midreset_sweep_len got=%0d exp=%0d", cnt, NREGS);
        end
        #1;
        checks++;
        if (rd_dat !== '0 || rd_busy !== 2'b00) begin
            failures++;
            $display("FAIL midreset_cleared got dat=%h busy=%b exp dat=0 busy=00",
                     rd_dat, rd_busy);
        end
        idle_inputs();
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        rst_n    = 1'b0;
        idle_inputs();
        test_reset();
        test_write_priority();
        test_zero_reg();
        test_scoreboard();
        test_issue_vs_write_flush();
        test_mid_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
